// File: rtl/sdram_pkg.sv
// Shared constants and arbiter state encoding for the SDRAM client front end.
package sdram_pkg;

    localparam int unsigned ROW_BITS   = 13;
    localparam int unsigned COL_BITS   = 9;
    localparam int unsigned BANK_BITS  = 2;
    localparam int unsigned ADDR_W_DEF = ROW_BITS + COL_BITS + BANK_BITS;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        S_ARB      = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RSP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sdram_rr_pick.sv
// Two-way round-robin winner: on a tie the port that did not win last time is chosen.
module sdram_rr_pick
    import sdram_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic any_o,
    output logic winner_o
);

    always_comb begin
        any_o = valid0_i | valid1_i;
        if (valid0_i && valid1_i) begin
            winner_o = ~last_grant_i;
        end else begin
            winner_o = valid1_i;
        end
    end

endmodule

// File: rtl/sdram_port_arb.sv
// Two-port front end for the SDRAM controller: round-robin arbitration, a held command
// across the controller's input register, and read-response routing to the issuing port.
module sdram_port_arb
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned RSP_TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_cmd_valid,
    output logic              p0_cmd_ready,
    input  logic              p0_cmd_write,
    input  logic [ADDR_W-1:0] p0_cmd_addr,
    input  logic [DATA_W-1:0] p0_cmd_wdata,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    input  logic              p1_cmd_valid,
    output logic              p1_cmd_ready,
    input  logic              p1_cmd_write,
    input  logic [ADDR_W-1:0] p1_cmd_addr,
    input  logic [DATA_W-1:0] p1_cmd_wdata,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              ctrl_cmd_valid,
    input  logic              ctrl_cmd_ready,
    output logic              ctrl_cmd_write,
    output logic [ADDR_W-1:0] ctrl_cmd_addr,
    output logic [DATA_W-1:0] ctrl_cmd_wdata,
    input  logic              ctrl_rsp_valid,
    output logic              ctrl_rsp_ready,
    input  logic [DATA_W-1:0] ctrl_rsp_rdata,
    output logic              grant_id,
    output logic              error_flag
);

    localparam int unsigned     CNT_W   = $clog2(RSP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RSP_TIMEOUT);

    arb_state_e        state_q;
    logic              presented_q;
    logic              last_grant_q;
    logic              grant_q;
    logic              error_q;
    logic              hold_write_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [DATA_W-1:0] hold_wdata_q;
    logic [CNT_W-1:0]  cnt_q;

    logic             any_valid;
    logic             winner;
    logic             in_issue;
    logic             in_wait;
    logic             handshake;
    logic             accept;
    logic             rsp_done;
    logic             sel_rsp_ready;
    logic             state_change;
    logic [CNT_W-1:0] cnt_sat;

    sdram_rr_pick u_pick (
        .valid0_i     (p0_cmd_valid),
        .valid1_i     (p1_cmd_valid),
        .last_grant_i (last_grant_q),
        .any_o        (any_valid),
        .winner_o     (winner)
    );

    always_comb begin
        in_issue      = (state_q == S_ISSUE);
        in_wait       = (state_q == S_WAIT_RSP);
        handshake     = (state_q == S_ARB) && any_valid;
        // The controller registers its inputs, so it only sees the command from the second cycle.
        accept        = in_issue && presented_q && ctrl_cmd_ready;
        sel_rsp_ready = grant_q ? p1_rsp_ready : p0_rsp_ready;
        rsp_done      = in_wait && ctrl_rsp_valid && sel_rsp_ready;
        state_change  = handshake || accept || rsp_done;
        cnt_sat       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        p0_cmd_ready   = handshake && !winner && !rst;
        p1_cmd_ready   = handshake && winner && !rst;
        ctrl_cmd_valid = in_issue;
        ctrl_cmd_write = hold_write_q;
        ctrl_cmd_addr  = hold_addr_q;
        ctrl_cmd_wdata = hold_wdata_q;
        ctrl_rsp_ready = in_wait && sel_rsp_ready;
        p0_rsp_valid   = in_wait && !grant_q && ctrl_rsp_valid;
        p1_rsp_valid   = in_wait && grant_q && ctrl_rsp_valid;
        p0_rsp_rdata   = (in_wait && !grant_q) ? ctrl_rsp_rdata : '0;
        p1_rsp_rdata   = (in_wait && grant_q) ? ctrl_rsp_rdata : '0;
        grant_id       = grant_q;
        error_flag     = error_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_ARB;
            presented_q  <= 1'b0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            error_q      <= 1'b0;
            hold_write_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            cnt_q        <= '0;
        end else begin
            unique case (state_q)
                S_ARB: begin
                    if (handshake) begin
                        hold_write_q <= winner ? p1_cmd_write : p0_cmd_write;
                        hold_addr_q  <= winner ? p1_cmd_addr : p0_cmd_addr;
                        hold_wdata_q <= winner ? p1_cmd_wdata : p0_cmd_wdata;
                        grant_q      <= winner;
                        last_grant_q <= winner;
                        presented_q  <= 1'b0;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    presented_q <= 1'b1;
                    if (accept) begin
                        state_q <= hold_write_q ? S_ARB : S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (rsp_done) begin
                        state_q <= S_ARB;
                    end
                end
                default: state_q <= S_ARB;
            endcase

            if (state_change) begin
                cnt_q <= '0;
            end else if (state_q != S_ARB) begin
                cnt_q <= cnt_sat;
                if (cnt_sat == CNT_MAX) begin
                    error_q <= 1'b1;
                end
            end

            // A response with nothing outstanding is a protocol error on the controller side.
            if (ctrl_rsp_valid && !in_wait) begin
                error_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Self-checking bench for sdram_port_arb: directed scenarios plus a randomized run
// checked against a transaction-level model of the two-port front end.
module tb_sdram_port_arb;

    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          p0_cmd_valid, p0_cmd_ready, p0_cmd_write, p0_rsp_valid, p0_rsp_ready;
    logic [AW-1:0] p0_cmd_addr;
    logic [DW-1:0] p0_cmd_wdata, p0_rsp_rdata;
    logic          p1_cmd_valid, p1_cmd_ready, p1_cmd_write, p1_rsp_valid, p1_rsp_ready;
    logic [AW-1:0] p1_cmd_addr;
    logic [DW-1:0] p1_cmd_wdata, p1_rsp_rdata;
    logic          ctrl_cmd_valid, ctrl_cmd_ready, ctrl_cmd_write;
    logic [AW-1:0] ctrl_cmd_addr;
    logic [DW-1:0] ctrl_cmd_wdata, ctrl_rsp_rdata;
    logic          ctrl_rsp_valid, ctrl_rsp_ready, grant_id, error_flag;

    int vectors     = 0;
    int miscompares = 0;

    sdram_port_arb #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .RSP_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .p0_cmd_valid   (p0_cmd_valid),
        .p0_cmd_ready   (p0_cmd_ready),
        .p0_cmd_write   (p0_cmd_write),
        .p0_cmd_addr    (p0_cmd_addr),
        .p0_cmd_wdata   (p0_cmd_wdata),
        .p0_rsp_valid   (p0_rsp_valid),
        .p0_rsp_ready   (p0_rsp_ready),
        .p0_rsp_rdata   (p0_rsp_rdata),
        .p1_cmd_valid   (p1_cmd_valid),
        .p1_cmd_ready   (p1_cmd_ready),
        .p1_cmd_write   (p1_cmd_write),
        .p1_cmd_addr    (p1_cmd_addr),
        .p1_cmd_wdata   (p1_cmd_wdata),
        .p1_rsp_valid   (p1_rsp_valid),
        .p1_rsp_ready   (p1_rsp_ready),
        .p1_rsp_rdata   (p1_rsp_rdata),
        .ctrl_cmd_valid (ctrl_cmd_valid),
        .ctrl_cmd_ready (ctrl_cmd_ready),
        .ctrl_cmd_write (ctrl_cmd_write),
        .ctrl_cmd_addr  (ctrl_cmd_addr),
        .ctrl_cmd_wdata (ctrl_cmd_wdata),
        .ctrl_rsp_valid (ctrl_rsp_valid),
        .ctrl_rsp_ready (ctrl_rsp_ready),
        .ctrl_rsp_rdata (ctrl_rsp_rdata),
        .grant_id       (grant_id),
        .error_flag     (error_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_cmd_valid = 0; p0_cmd_write = 0; p0_cmd_addr = '0; p0_cmd_wdata = '0; p0_rsp_ready = 0;
        p1_cmd_valid = 0; p1_cmd_write = 0; p1_cmd_addr = '0; p1_cmd_wdata = '0; p1_rsp_ready = 0;
        ctrl_cmd_ready = 0; ctrl_rsp_valid = 0; ctrl_rsp_rdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #1 rst = 1'b1;
        p0_cmd_valid = 1; p1_cmd_valid = 1; ctrl_rsp_valid = 1; ctrl_rsp_rdata = 16'hFFFF;
        p0_rsp_ready = 1; p1_rsp_ready = 1; ctrl_cmd_ready = 1;
        #3;
        vectors++;
        if ({p0_cmd_ready, p1_cmd_ready, p0_rsp_valid, p1_rsp_valid, ctrl_cmd_valid,
             ctrl_rsp_ready, grant_id, error_flag} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b required 00000000", {p0_cmd_ready, p1_cmd_ready,
                     p0_rsp_valid, p1_rsp_valid, ctrl_cmd_valid, ctrl_rsp_ready, grant_id, error_flag});
        end
        vectors++;
        if ({ctrl_cmd_write, ctrl_cmd_addr, ctrl_cmd_wdata, p0_rsp_rdata, p1_rsp_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_payload: got %h/%h/%h/%h/%h required all zero", ctrl_cmd_write,
                     ctrl_cmd_addr, ctrl_cmd_wdata, p0_rsp_rdata, p1_rsp_rdata);
        end
        tick();
        ctrl_rsp_valid = 0;
        rst = 1'b0;
        #1;
        vectors++;
        if ({p0_cmd_ready, p1_cmd_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL first_tie: got ready=%b required 10", {p0_cmd_ready, p1_cmd_ready});
        end
        apply_reset();
    endtask

    task automatic test_port0_write();
        apply_reset();
        p0_cmd_valid = 1; p0_cmd_write = 1; p0_cmd_addr = 24'h000123; p0_cmd_wdata = 16'hBEEF;
        ctrl_cmd_ready = 1;
        #1;
        vectors++;
        if ({p0_cmd_ready, p1_cmd_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL wr_grant: got ready=%b required 10", {p0_cmd_ready, p1_cmd_ready});
        end
        tick();
        p0_cmd_valid = 0;
        p1_cmd_valid = 1; p1_cmd_write = 0; p1_cmd_addr = 24'h0000AA;
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++;
            if ({ctrl_cmd_valid, ctrl_cmd_write, ctrl_cmd_addr, ctrl_cmd_wdata, p1_cmd_ready,
                 p0_rsp_valid} !== {1'b1, 1'b1, 24'h000123, 16'hBEEF, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL wr_issue%0d: got v=%b w=%b a=%h d=%h p1rdy=%b p0rsp=%b required 1 1 000123 beef 0 0",
                         c, ctrl_cmd_valid, ctrl_cmd_write, ctrl_cmd_addr, ctrl_cmd_wdata,
                         p1_cmd_ready, p0_rsp_valid);
            end
            tick();
        end
        #1;
        vectors++;
        if ({ctrl_cmd_valid, p1_cmd_ready, p0_rsp_valid} !== 3'b010) begin
            miscompares++;
            $display("FAIL wr_drop: got valid/p1rdy/p0rsp=%b required 010",
                     {ctrl_cmd_valid, p1_cmd_ready, p0_rsp_valid});
        end
    endtask

    task automatic test_port1_read();
        apply_reset();
        p1_cmd_valid = 1; p1_cmd_write = 0; p1_cmd_addr = 24'h00A5A4; p1_cmd_wdata = 16'h0777;
        ctrl_cmd_ready = 1; p1_rsp_ready = 1; p0_rsp_ready = 1;
        #1;
        vectors++;
        if ({p0_cmd_ready, p1_cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rd_grant: got ready=%b required 01", {p0_cmd_ready, p1_cmd_ready});
        end
        tick();
        p1_cmd_valid = 0;
        #1;
        vectors++;
        if ({ctrl_cmd_valid, ctrl_cmd_write, ctrl_cmd_addr, grant_id} !== {1'b1, 1'b0, 24'h00A5A4, 1'b1}) begin
            miscompares++;
            $display("FAIL rd_issue: got v=%b w=%b a=%h gid=%b required 1 0 00a5a4 1",
                     ctrl_cmd_valid, ctrl_cmd_write, ctrl_cmd_addr, grant_id);
        end
        tick();
        tick();
        ctrl_rsp_valid = 1; ctrl_rsp_rdata = 16'h1234;
        #1;
        vectors++;
        if ({p1_rsp_valid, p1_rsp_rdata, p0_rsp_valid, p0_rsp_rdata, ctrl_rsp_ready, ctrl_cmd_valid}
            !== {1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rd_route: got p1v=%b p1d=%h p0v=%b p0d=%h crr=%b cv=%b required 1 1234 0 0000 1 0",
                     p1_rsp_valid, p1_rsp_rdata, p0_rsp_valid, p0_rsp_rdata, ctrl_rsp_ready, ctrl_cmd_valid);
        end
        tick();
        ctrl_rsp_valid = 0;
        p0_cmd_valid = 1;
        #1;
        vectors++;
        if ({p0_cmd_ready, p1_rsp_valid, ctrl_rsp_ready, error_flag} !== 4'b1000) begin
            miscompares++;
            $display("FAIL rd_back_to_arb: got p0rdy/p1rsp/crr/err=%b required 1000",
                     {p0_cmd_ready, p1_rsp_valid, ctrl_rsp_ready, error_flag});
        end
    endtask

    task automatic test_round_robin();
        int    grants[$];
        int    got  = 0;
        bit    seen = 0;
        int    exp_port;
        apply_reset();
        p0_cmd_valid = 1; p0_cmd_addr = 24'h000111;
        p1_cmd_valid = 1; p1_cmd_addr = 24'h000222;
        ctrl_cmd_ready = 1; p0_rsp_ready = 1; p1_rsp_ready = 1;
        for (int c = 0; c < 200 && got < 4; c++) begin
            ctrl_rsp_valid = 0;
            #1;
            if (p0_cmd_ready) grants.push_back(0);
            if (p1_cmd_ready) grants.push_back(1);
            if (ctrl_cmd_valid) begin
                seen = 1;
                exp_port = (grants.size() > 0) ? grants[grants.size() - 1] : 0;
                vectors++;
                if (ctrl_cmd_addr !== (exp_port == 1 ? 24'h000222 : 24'h000111)) begin
                    miscompares++;
                    $display("FAIL rr_addr: got %h for port %0d", ctrl_cmd_addr, exp_port);
                end
            end
            ctrl_rsp_valid = seen && !ctrl_cmd_valid;
            ctrl_rsp_rdata = 16'hC000 + 16'(got);
            #1;
            if (ctrl_rsp_valid) begin
                exp_port = (grants.size() > got) ? grants[got] : 0;
                vectors++;
                if ({p0_rsp_valid, p1_rsp_valid} !== (exp_port == 1 ? 2'b01 : 2'b10) ||
                    (exp_port == 1 ? p1_rsp_rdata : p0_rsp_rdata) !== 16'hC000 + 16'(got)) begin
                    miscompares++;
                    $display("FAIL rr_route%0d: got valid=%b d0=%h d1=%h required port %0d data %h",
                             got, {p0_rsp_valid, p1_rsp_valid}, p0_rsp_rdata, p1_rsp_rdata,
                             exp_port, 16'hC000 + 16'(got));
                end
                got++;
                seen = 0;
            end
            tick();
        end
        ctrl_rsp_valid = 0;
        vectors++;
        if (got !== 4) begin
            miscompares++;
            $display("FAIL rr_count: got %0d responses required 4", got);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (grants.size() <= i || grants[i] != i % 2) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got %0d required %0d", i,
                         (grants.size() > i) ? grants[i] : -1, i % 2);
            end
        end
        vectors++;
        if (error_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_err: got %b required 0", error_flag);
        end
    endtask

    task automatic test_refresh_stall();
        int bad = 0;
        int reissue = 0;
        apply_reset();
        p0_cmd_valid = 1; p0_cmd_write = 1; p0_cmd_addr = 24'hFFFFFF; p0_cmd_wdata = 16'h5A5A;
        ctrl_cmd_ready = 0;
        tick();
        p0_cmd_valid = 0;
        p1_cmd_valid = 1; p1_cmd_addr = 24'h000333;
        for (int c = 0; c < 50; c++) begin
            #1;
            if ({ctrl_cmd_valid, ctrl_cmd_write, ctrl_cmd_addr, ctrl_cmd_wdata, p1_cmd_ready}
                !== {1'b1, 1'b1, 24'hFFFFFF, 16'h5A5A, 1'b0}) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stall_hold: got %0d unstable cycles required 0", bad);
        end
        p1_cmd_valid = 0;
        ctrl_cmd_ready = 1;
        #1;
        vectors++;
        if (ctrl_cmd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_present: got valid=%b required 1", ctrl_cmd_valid);
        end
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            if (ctrl_cmd_valid) reissue++;
            tick();
        end
        vectors++;
        if (reissue != 0) begin
            miscompares++;
            $display("FAIL stall_once: got %0d extra issue cycles required 0", reissue);
        end
        vectors++;
        if (error_flag !== (50 >= TMO)) begin
            miscompares++;
            $display("FAIL stall_err: got %b required %b", error_flag, (50 >= TMO));
        end
    endtask

    task automatic test_rsp_backpressure();
        int bad = 0;
        apply_reset();
        p0_cmd_valid = 1; p0_cmd_addr = 24'h012345; ctrl_cmd_ready = 1; p0_rsp_ready = 0;
        tick();
        p0_cmd_valid = 0;
        tick();
        tick();
        ctrl_rsp_valid = 1; ctrl_rsp_rdata = 16'hCAFE;
        for (int c = 0; c < 10; c++) begin
            #1;
            if ({ctrl_rsp_ready, p0_rsp_valid, p0_rsp_rdata, p1_rsp_valid} !== {1'b0, 1'b1, 16'hCAFE, 1'b0})
                bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL bp_hold: got %0d bad cycles required 0", bad);
        end
        p0_rsp_ready = 1;
        #1;
        vectors++;
        if ({ctrl_rsp_ready, p0_rsp_valid} !== 2'b11) begin
            miscompares++;
            $display("FAIL bp_release: got crr/p0v=%b required 11", {ctrl_rsp_ready, p0_rsp_valid});
        end
        tick();
        ctrl_rsp_valid = 0;
        p1_cmd_valid = 1;
        #1;
        vectors++;
        if ({p1_cmd_ready, ctrl_rsp_ready, error_flag} !== 3'b100) begin
            miscompares++;
            $display("FAIL bp_done: got p1rdy/crr/err=%b required 100",
                     {p1_cmd_ready, ctrl_rsp_ready, error_flag});
        end
    endtask

    task automatic test_timeout_and_reset();
        apply_reset();
        p1_cmd_valid = 1; p1_cmd_addr = 24'h000444; ctrl_cmd_ready = 1; p1_rsp_ready = 1;
        tick();
        p1_cmd_valid = 0;
        tick();
        tick();
        repeat (TMO - 1) tick();
        vectors++;
        if (error_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_early: got %b after %0d cycles required 0", error_flag, TMO - 1);
        end
        tick();
        vectors++;
        if ({error_flag, ctrl_rsp_ready, grant_id} !== 3'b111) begin
            miscompares++;
            $display("FAIL tmo_set: got err/crr/gid=%b required 111", {error_flag, ctrl_rsp_ready, grant_id});
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({p0_cmd_ready, p1_cmd_ready, p0_rsp_valid, p1_rsp_valid, ctrl_cmd_valid,
             ctrl_rsp_ready, grant_id, error_flag, ctrl_cmd_addr} !== '0) begin
            miscompares++;
            $display("FAIL tmo_async_rst: got ctl=%b addr=%h required all zero",
                     {p0_cmd_ready, p1_cmd_ready, p0_rsp_valid, p1_rsp_valid, ctrl_cmd_valid,
                      ctrl_rsp_ready, grant_id, error_flag}, ctrl_cmd_addr);
        end
        apply_reset();
    endtask

    task automatic test_random();
        logic [1:0]    pv = 2'b00;
        logic          pw[2];
        logic [AW-1:0] pa[2];
        logic [DW-1:0] pd[2];
        bit            busy = 0, acc = 0, err = 0;
        int            seen = 0, cnt = 0, dly = 0, last = 1, gid = 0, op = 0, win;
        logic          ow, wt, sel_rdy;
        logic [AW-1:0] oa;
        logic [DW-1:0] od, rdat = '0, e_rd0, e_rd1;
        logic [7:0]    e_ctl;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 1) == 1) begin
                    pv[p] = 1'b1;
                    pw[p] = 1'($urandom_range(0, 1));
                    pa[p] = AW'($urandom);
                    pd[p] = DW'($urandom);
                end
            end
            p0_cmd_valid = pv[0]; p0_cmd_write = pw[0]; p0_cmd_addr = pa[0]; p0_cmd_wdata = pd[0];
            p1_cmd_valid = pv[1]; p1_cmd_write = pw[1]; p1_cmd_addr = pa[1]; p1_cmd_wdata = pd[1];
            ctrl_cmd_ready = ($urandom_range(0, 9) < 7);
            p0_rsp_ready   = ($urandom_range(0, 9) < 7);
            p1_rsp_ready   = ($urandom_range(0, 9) < 7);
            ctrl_rsp_valid = busy && acc && dly == 0;
            ctrl_rsp_rdata = ctrl_rsp_valid ? rdat : DW'($urandom);
            #1;
            win     = (pv == 2'b11) ? 1 - last : (pv[1] ? 1 : 0);
            wt      = busy && acc;
            sel_rdy = (op == 1) ? p1_rsp_ready : p0_rsp_ready;
            e_ctl   = {!busy && pv != 0 && win == 0, !busy && pv != 0 && win == 1, busy && !acc,
                       wt && sel_rdy, wt && op == 0 && ctrl_rsp_valid, wt && op == 1 && ctrl_rsp_valid,
                       1'(gid), err};
            e_rd0   = (wt && op == 0) ? ctrl_rsp_rdata : '0;
            e_rd1   = (wt && op == 1) ? ctrl_rsp_rdata : '0;
            vectors++;
            if ({p0_cmd_ready, p1_cmd_ready, ctrl_cmd_valid, ctrl_rsp_ready, p0_rsp_valid,
                 p1_rsp_valid, grant_id, error_flag} !== e_ctl) begin
                miscompares++;
                $display("FAIL rand_ctl cyc %0d: got %b required %b", c, {p0_cmd_ready, p1_cmd_ready,
                         ctrl_cmd_valid, ctrl_rsp_ready, p0_rsp_valid, p1_rsp_valid, grant_id,
                         error_flag}, e_ctl);
            end
            vectors++;
            if ({p0_rsp_rdata, p1_rsp_rdata} !== {e_rd0, e_rd1}) begin
                miscompares++;
                $display("FAIL rand_rdata cyc %0d: got %h/%h required %h/%h", c, p0_rsp_rdata,
                         p1_rsp_rdata, e_rd0, e_rd1);
            end
            if (busy && !acc) begin
                vectors++;
                if ({ctrl_cmd_write, ctrl_cmd_addr, ctrl_cmd_wdata} !== {ow, oa, od}) begin
                    miscompares++;
                    $display("FAIL rand_payload cyc %0d: got %b %h %h required %b %h %h", c,
                             ctrl_cmd_write, ctrl_cmd_addr, ctrl_cmd_wdata, ow, oa, od);
                end
            end
            // Advance the transaction model to the next clock edge.
            if (!busy) begin
                if (pv != 0) begin
                    busy = 1; acc = 0; seen = 0; cnt = 0;
                    op = win; ow = pw[win]; oa = pa[win]; od = pd[win];
                    last = win; gid = win; pv[win] = 1'b0;
                end
            end else if (!acc) begin
                if (seen > 0 && ctrl_cmd_ready) begin
                    cnt = 0;
                    if (ow) busy = 0;
                    else begin
                        acc  = 1;
                        dly  = $urandom_range(0, 5);
                        rdat = DW'($urandom);
                    end
                end else begin
                    cnt++;
                    if (cnt >= TMO) err = 1;
                end
                seen++;
            end else begin
                if (ctrl_rsp_valid && sel_rdy) busy = 0;
                else begin
                    cnt++;
                    if (cnt >= TMO) err = 1;
                    if (dly > 0) dly--;
                end
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_port0_write();
        test_port1_read();
        test_round_robin();
        test_refresh_stall();
        test_rsp_backpressure();
        test_timeout_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
